// File: rtl/acs_path_metric.sv
// acs_path_metric: K=3 rate-1/2 Viterbi add-compare-select with renormalised path metrics
module acs_path_metric #(
  parameter int PM_W  = 6,
  parameter int INIT  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             bm_valid,
  input  logic [1:0]       bm_00,
  input  logic [1:0]       bm_01,
  input  logic [1:0]       bm_10,
  input  logic [1:0]       bm_11,
  output logic             dec_valid,
  output logic [3:0]       dec,
  output logic [PM_W-1:0]  pm_0,
  output logic [PM_W-1:0]  pm_1,
  output logic [PM_W-1:0]  pm_2,
  output logic [PM_W-1:0]  pm_3,
  output logic [1:0]       best_state,
  output logic [CNT_W-1:0] step_cnt
);
  // codeword on the p0 branch into each next state; the p1 branch is its complement
  localparam logic [3:0][1:0] CW0 = {2'b01, 2'b11, 2'b10, 2'b00};
  logic [3:0][1:0]      bm;
  logic [3:0][PM_W:0]   c0, c1, sel;
  logic [PM_W:0]        m;
  logic [3:0][PM_W-1:0] pm_q, pm_d, nrm;
  logic [3:0]           dec_q, dec_d, pick;
  logic [1:0]           best_q, best_d, bst;
  logic                 dec_valid_q, dec_valid_d;
  logic [CNT_W-1:0]     step_cnt_q, step_cnt_d;
  always_comb begin
    bm = {bm_11, bm_10, bm_01, bm_00};
    m = '1;
    for (int i = 0; i < 4; i++) begin
      c0[i[1:0]] = {1'b0, pm_q[{i[0], 1'b0}]} + {{(PM_W-1){1'b0}}, bm[CW0[i[1:0]]]};
      c1[i[1:0]] = {1'b0, pm_q[{i[0], 1'b1}]} + {{(PM_W-1){1'b0}}, bm[~CW0[i[1:0]]]};
      pick[i[1:0]] = c1[i[1:0]] < c0[i[1:0]];
      sel[i[1:0]] = pick[i[1:0]] ? c1[i[1:0]] : c0[i[1:0]];
      m = sel[i[1:0]] < m ? sel[i[1:0]] : m;
    end
    bst = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      nrm[i[1:0]] = PM_W'(sel[i[1:0]] - m);
      bst = nrm[i[1:0]] == '0 ? i[1:0] : bst;
    end
    pm_d        = bm_valid ? nrm : pm_q;
    dec_d       = bm_valid ? pick : dec_q;
    best_d      = bm_valid ? bst : best_q;
    dec_valid_d = bm_valid;
    step_cnt_d  = bm_valid ? step_cnt_q + 1'b1 : step_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst || init) begin
      pm_q        <= {PM_W'(INIT), PM_W'(INIT), PM_W'(INIT), PM_W'(0)};
      dec_q       <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      best_q      <= best_d;
      dec_valid_q <= dec_valid_d;
      step_cnt_q  <= step_cnt_d;
    end
  end
  assign pm_0       = pm_q[0];
  assign pm_1       = pm_q[1];
  assign pm_2       = pm_q[2];
  assign pm_3       = pm_q[3];
  assign dec        = dec_q;
  assign best_state = best_q;
  assign dec_valid  = dec_valid_q;
  assign step_cnt   = step_cnt_q;
endmodule

// File: doc/acs_path_metric.md
# acs_path_metric

Add-compare-select and path-metric unit for the rate-1/2, K=3 (generators 7/5 octal) Viterbi decoder. Sits directly downstream of the branch-metric stage: each accepted step takes the four 2-bit Hamming branch metrics for the received pair, updates four registered path metrics, and emits one survivor decision bit per state to the traceback memory. Metrics are renormalised every step so the smallest metric is always 0.

## Interface
- PM_W, 6: path-metric width; legal range 4..16.
- INIT, 4: reset/init metric for states 1..3; legal range 1..2^PM_W-3.
- CNT_W, 8: step-counter width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- init  in  1  one-cycle frame restart; same effect as rst.
- bm_valid  in  1  branch metrics valid this cycle; each high cycle is one trellis step.
- bm_00, bm_01, bm_10, bm_11  in  2 each  Hamming distance between rx pair and codeword {c1,c0}, range 0..2.
- dec_valid  out  1  one-cycle strobe; dec, pm_*, best_state hold the new step.
- dec  out  4  survivor bit per next state; dec[s]=1 selects predecessor p1.
- pm_0..pm_3  out  PM_W each  registered normalised path metrics.
- best_state  out  2  index of the minimum pm; lowest index on tie.
- step_cnt  out  CNT_W  accepted steps since rst/init; wraps modulo 2^CNT_W.

## Operation
- State s = {u[n-1],u[n-2]}; next state ns = {u, s[1]}; predecessors of ns are p0={ns[0],0}, p1={ns[0],1}.
- Branch codewords (p0 / p1): ns0: 00 / 11; ns1: 10 / 01; ns2: 11 / 00; ns3: 01 / 10.
- Candidates: cand0 = pm[p0]+bm[cw_p0], cand1 = pm[p1]+bm[cw_p1], computed at PM_W+1 bits.
- Select: if cand1 < cand0 take cand1, dec[ns]=1; otherwise, including ties, take cand0, dec[ns]=0.
- Normalise: m = min of the four selected values; pm[ns] <= selected - m. At least one pm is 0 after every step.
- Given the PM_W/INIT limits, no overflow occurs; saturation logic is not required.
- best_state is the index of the minimum after normalisation, lowest index on tie. It is registered with the pms.
- rst or init: pm_0=0, pm_1=pm_2=pm_3=INIT, dec=0, best_state=0, dec_valid=0, step_cnt=0.
- init overrides bm_valid in the same cycle; that step is discarded.
- bm_valid low: all outputs hold, and dec_valid=0 the next cycle.

## Timing
- Latency 1: metrics sampled at edge k with bm_valid=1 appear on pm_*/dec/best_state after edge k, with dec_valid=1 for exactly that cycle.
- Back-to-back bm_valid: one step per cycle, no bubbles, and dec_valid stays high continuously.
- No backpressure; the downstream stage must accept every dec_valid.
- step_cnt increments on each accepted step; 2^CNT_W-1 wraps to 0.
- rst asserted mid-stream: reset values are visible the cycle after the edge, and the in-flight step is lost.

## Test plan
- Reset: hold rst 2 cycles -> pm=(0,4,4,4), dec_valid=0, best_state=0, step_cnt=0.
- Two steps rx 00 (bm_00=0, bm_01=1, bm_10=1, bm_11=2) from reset -> step1 pm=(0,5,2,5), dec=0000, best_state=0; step2 pm=(0,3,2,3), dec=0000, step_cnt=2.
- From reset: rx 11 (2,1,1,0), then 01 (1,0,2,1), then 00 (0,1,1,2) -> pm (2,5,0,5) best 2; then (3,2,3,0) best 3; then (2,0,1,0), dec=1110, best_state=1 (tie, lowest index).
- Gapped stream: bm_valid high, low, low, high -> dec_valid high only the cycle after each valid edge, and outputs stable during the gaps.
- init together with bm_valid mid-stream -> next cycle pm=(0,4,4,4), dec_valid=0, step_cnt=0.
- Random 10k-step stream from an encoded message (with ≤1 error per 5 pairs) -> min pm is always 0, no pm exceeds INIT+4, step_cnt matches modulo 256, and a reference-model traceback recovers the message.
